// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator/requantization path: relu modes,
// scale pipeline latency and the scale_sched state type.
package acc_pkg;

    localparam int unsigned SCALE_LAT = 4;

    localparam logic [1:0] RELU_NONE  = 2'b00;
    localparam logic [1:0] RELU_ON    = 2'b10;
    localparam logic [1:0] RELU_LEAKY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; only the pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/scale_sched.sv
// Requantization sequencer: issues accumulator beats with per-group scale
// multipliers into the fixed-latency scale pipeline and buffers its results.
module scale_sched
    import acc_pkg::*;
#(
    parameter int unsigned DN     = 6,
    parameter int unsigned DW     = 22,
    parameter int unsigned MULW   = 9,
    parameter int unsigned OW     = 8,
    parameter int unsigned PAW    = 5,
    parameter int unsigned BCW    = 16,
    parameter int unsigned FDEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [BCW-1:0]       cfg_beats,
    input  logic [PAW:0]         cfg_groups,
    input  logic [4:0]           cfg_n,
    input  logic [1:0]           cfg_relu,
    input  logic                 prm_we,
    input  logic [PAW-1:0]       prm_addr,
    input  logic [DN*MULW-1:0]   prm_wdata,
    input  logic [DN*DW-1:0]     acc_data,
    input  logic                 acc_valid,
    output logic                 acc_ready,
    output logic [DN*DW-1:0]     sc_data1,
    output logic                 sc_valid1,
    output logic [DN*MULW-1:0]   sc_data2,
    output logic [4:0]           sc_n,
    output logic [1:0]           sc_relu,
    input  logic [DN*OW-1:0]     sc_sdata,
    input  logic                 sc_svalid,
    output logic [DN*OW-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned CRW = $clog2(FDEPTH) + 1;
    localparam int unsigned NGRP = 2 ** PAW;

    sched_state_t state;
    sched_state_t state_nxt;

    logic [BCW-1:0]     beats_q;
    logic [BCW-1:0]     beat_q;
    logic [PAW:0]       groups_q;
    logic [PAW-1:0]     grp_q;
    logic [4:0]         n_q;
    logic [1:0]         relu_q;
    logic [CRW-1:0]     credits_q;
    logic               done_q;
    logic               err_q;

    logic [DN*MULW-1:0] prm_mem [NGRP];

    logic               issue;
    logic               pop;
    logic               start;
    logic               last_beat;
    logic               grp_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CRW-1:0]     fifo_count;
    logic [DN*OW-1:0]   fifo_rdata;

    assign start     = (state == ST_IDLE) && cfg_start;
    assign acc_ready = (state == ST_RUN) && (credits_q != '0);
    assign issue     = acc_valid && acc_ready;
    assign pop       = out_valid && out_ready;
    assign last_beat = (beat_q == beats_q - BCW'(1));
    assign grp_last  = ({1'b0, grp_q} == groups_q - (PAW+1)'(1));

    // Issue path is a same-cycle pass-through, held at zero when idle.
    assign sc_valid1 = issue;
    assign sc_data1  = issue ? acc_data : '0;
    assign sc_data2  = issue ? prm_mem[grp_q] : '0;
    assign sc_n      = n_q;
    assign sc_relu   = relu_q;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata;
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (prm_we && (state == ST_IDLE)) begin
            prm_mem[prm_addr] <= prm_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_beats == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_beat) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (credits_q == CRW'(FDEPTH)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Layer configuration and beat/group counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            groups_q <= '0;
            n_q      <= '0;
            relu_q   <= '0;
            beat_q   <= '0;
            grp_q    <= '0;
        end else if (start) begin
            beats_q  <= cfg_beats;
            groups_q <= cfg_groups;
            n_q      <= cfg_n;
            relu_q   <= cfg_relu;
            beat_q   <= '0;
            grp_q    <= '0;
        end else if (issue) begin
            beat_q   <= beat_q + BCW'(1);
            grp_q    <= grp_last ? '0 : grp_q + PAW'(1);
        end
    end

    // Credits cover FIFO entries plus beats still inside the scale pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CRW'(FDEPTH);
        end else if (issue && !pop) begin
            credits_q <= credits_q - CRW'(1);
        end else if (pop && !issue && (credits_q != CRW'(FDEPTH))) begin
            credits_q <= credits_q + CRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            if (sc_svalid && fifo_full && !pop) begin
                err_q <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DN*OW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sc_svalid),
        .wdata (sc_sdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ((CRW+1)'(credits_q) + (CRW+1)'(fifo_count) <= (CRW+1)'(FDEPTH)));

endmodule

// File: tb/tb_scale_sched.sv
// Self-checking bench for scale_sched: behavioural scale pipeline, result
// scoreboard, directed corner sequences and table-driven randomized passes.
module tb_scale_sched;
    import acc_pkg::*;

    localparam int unsigned DN = 6, DW = 22, MULW = 9, OW = 8;
    localparam int unsigned PAW = 5, BCW = 16, FDEPTH = 8;

    logic                 clk, rst_n;
    logic                 cfg_start;
    logic [BCW-1:0]       cfg_beats;
    logic [PAW:0]         cfg_groups;
    logic [4:0]           cfg_n;
    logic [1:0]           cfg_relu;
    logic                 prm_we;
    logic [PAW-1:0]       prm_addr;
    logic [DN*MULW-1:0]   prm_wdata;
    logic [DN*DW-1:0]     acc_data;
    logic                 acc_valid, acc_ready;
    logic [DN*DW-1:0]     sc_data1;
    logic                 sc_valid1;
    logic [DN*MULW-1:0]   sc_data2;
    logic [4:0]           sc_n;
    logic [1:0]           sc_relu;
    logic [DN*OW-1:0]     sc_sdata;
    logic                 sc_svalid;
    logic [DN*OW-1:0]     out_data;
    logic                 out_valid, out_ready;
    logic                 busy, done, err;

    scale_sched #(.DN(DN), .DW(DW), .MULW(MULW), .OW(OW), .PAW(PAW),
                  .BCW(BCW), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_beats(cfg_beats),
        .cfg_groups(cfg_groups), .cfg_n(cfg_n), .cfg_relu(cfg_relu),
        .prm_we(prm_we), .prm_addr(prm_addr), .prm_wdata(prm_wdata),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .sc_data1(sc_data1), .sc_valid1(sc_valid1), .sc_data2(sc_data2),
        .sc_n(sc_n), .sc_relu(sc_relu), .sc_sdata(sc_sdata), .sc_svalid(sc_svalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scale block behaviour: per lane (acc * mul) >> n, low OW bits.
    function automatic logic [DN*OW-1:0] scale_f(input logic [DN*DW-1:0] a,
                                                 input logic [DN*MULW-1:0] m,
                                                 input logic [4:0] n);
        logic [DN*OW-1:0] r;
        logic [63:0]      p;
        r = '0;
        for (int i = 0; i < DN; i++) begin
            p = (64'(a[i*DW +: DW]) * 64'(m[i*MULW +: MULW])) >> n;
            r[i*OW +: OW] = p[OW-1:0];
        end
        return r;
    endfunction

    function automatic logic [DN*DW-1:0] rand_acc();
        logic [DN*DW-1:0] r;
        for (int i = 0; i < DN; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [DN*MULW-1:0] rand_mul();
        logic [DN*MULW-1:0] r;
        for (int i = 0; i < DN; i++) r[i*MULW +: MULW] = MULW'($urandom);
        return r;
    endfunction

    // Four-stage scale pipeline stand-in, reset together with the DUT.
    logic [3:0]       pv;
    logic [DN*OW-1:0] pd [4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], sc_valid1};
            pd[0] <= scale_f(sc_data1, sc_data2, sc_n);
            for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
        end
    end
    assign sc_svalid = pv[3];
    assign sc_sdata  = pd[3];

    // Reference model state.
    logic [DN*MULW-1:0] tbl_mdl [32];
    int                 mdl_grp, mdl_groups;
    logic [4:0]         mdl_n;
    logic [DN*OW-1:0]   exp_q [$];
    logic [MULW-1:0]    obs_q [$];
    int                 n_issue, n_out, n_done;

    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_valid && acc_ready) begin
                check("sc_valid1", sc_valid1, 1);
                check("sc_data1", sc_data1, acc_data);
                check("sc_data2", sc_data2, tbl_mdl[mdl_grp]);
                check("sc_n", sc_n, mdl_n);
                obs_q.push_back(sc_data2[MULW-1:0]);
                exp_q.push_back(scale_f(acc_data, tbl_mdl[mdl_grp], mdl_n));
                mdl_grp = (mdl_grp + 1 >= mdl_groups) ? 0 : mdl_grp + 1;
                n_issue++;
            end else if (sc_valid1 !== 1'b0) begin
                check("sc_valid1_idle", sc_valid1, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
                else check("out_data", out_data, exp_q.pop_front());
                n_out++;
            end
            if (done) begin
                n_done++;
                check("done_pending", exp_q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_issue = 0;
        n_out   = 0;
        n_done  = 0;
        obs_q.delete();
    endtask

    task automatic write_prm(input int addr, input logic [DN*MULW-1:0] d);
        prm_we = 1'b1; prm_addr = PAW'(addr); prm_wdata = d;
        tick();
        prm_we = 1'b0;
        tbl_mdl[addr] = d;
    endtask

    task automatic start_pass(input int beats, input int groups, input int n, input logic [1:0] relu);
        clear_counts();
        mdl_grp = 0; mdl_groups = groups; mdl_n = 5'(n);
        cfg_beats = BCW'(beats); cfg_groups = (PAW+1)'(groups);
        cfg_n = 5'(n); cfg_relu = relu; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic run_to_done(input int vpct, input int rpct, input int maxc);
        for (int c = 0; c < maxc && n_done == 0; c++) begin
            acc_valid = ($urandom_range(99) < vpct);
            acc_data  = rand_acc();
            out_ready = ($urandom_range(99) < rpct);
            tick();
        end
        acc_valid = 1'b0;
        out_ready = 1'b1;
        check("pass_done", n_done, 1);
        repeat (3) tick();
        check("done_once", n_done, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc_ready"}, acc_ready, 0);
        check({tag, "_sc_valid1"}, sc_valid1, 0);
        check({tag, "_sc_data1"}, sc_data1, 0);
        check({tag, "_sc_data2"}, sc_data2, 0);
        check({tag, "_sc_n"}, sc_n, 0);
        check({tag, "_sc_relu"}, sc_relu, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_credits"}, dut.credits_q, FDEPTH);
    endtask

    typedef struct {
        int         beats;
        int         groups;
        int         n;
        logic [1:0] relu;
        int         vpct;
        int         rpct;
        int         exp_outs;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{beats: 5,  groups: 1,  n: 0,  relu: RELU_ON,    vpct: 100, rpct: 100, exp_outs: 5};
        vecs[1] = '{beats: 13, groups: 4,  n: 7,  relu: RELU_LEAKY, vpct: 70,  rpct: 50,  exp_outs: 13};
        vecs[2] = '{beats: 40, groups: 32, n: 21, relu: RELU_LEAKY, vpct: 90,  rpct: 30,  exp_outs: 40};
        vecs[3] = '{beats: 9,  groups: 7,  n: 3,  relu: RELU_NONE,  vpct: 50,  rpct: 100, exp_outs: 9};
        vecs[4] = '{beats: 25, groups: 5,  n: 12, relu: RELU_ON,    vpct: 100, rpct: 80,  exp_outs: 25};

        rst_n = 1'b0; cfg_start = 1'b0; cfg_beats = '0; cfg_groups = '0;
        cfg_n = '0; cfg_relu = '0; prm_we = 1'b0; prm_addr = '0; prm_wdata = '0;
        acc_valid = 1'b0; acc_data = rand_acc(); out_ready = 1'b0;
        mdl_grp = 0; mdl_groups = 1; mdl_n = '0;
        clear_counts();
        repeat (2) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Parameter mapping: groups 0..2 hold 1,2,3 in every lane.
        for (int g = 0; g < 3; g++) write_prm(g, {DN{MULW'(g + 1)}});
        start_pass(6, 3, 10, RELU_NONE);
        run_to_done(100, 100, 200);
        check("map_count", obs_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < obs_q.size()) check("map_seq", obs_q[i], (i % 3) + 1);
        check("map_outs", n_out, 6);

        // Latency: single beat reaches the FIFO head SCALE_LAT+1 cycles on.
        start_pass(1, 3, 6, RELU_NONE);
        acc_valid = 1'b1; acc_data = rand_acc(); out_ready = 1'b0;
        tick();
        acc_valid = 1'b0;
        for (int k = 1; k <= SCALE_LAT; k++) begin
            tick();
            check("latency_head", out_valid, (k == SCALE_LAT));
        end
        run_to_done(0, 100, 100);
        check("latency_outs", n_out, 1);

        // Backpressure: exactly FDEPTH beats accepted with out_ready low.
        start_pass(20, 3, 5, RELU_ON);
        acc_valid = 1'b1; out_ready = 1'b0;
        repeat (20) begin
            acc_data = rand_acc();
            tick();
        end
        check("bp_issued", n_issue, FDEPTH);
        check("bp_acc_ready", acc_ready, 0);
        check("bp_fifo_count", dut.u_fifo.count, FDEPTH);
        check("bp_err", err, 0);
        check("bp_relu", sc_relu, RELU_ON);
        run_to_done(100, 100, 500);
        check("bp_outs", n_out, 20);

        // Simultaneous issue and pop with a single credit left.
        start_pass(30, 3, 4, RELU_LEAKY);
        acc_valid = 1'b1; out_ready = 1'b0;
        repeat (FDEPTH - 1) begin
            acc_data = rand_acc();
            tick();
        end
        acc_valid = 1'b0;
        repeat (8) tick();
        check("sim_credits_pre", dut.credits_q, 1);
        check("sim_fifo_pre", dut.u_fifo.count, FDEPTH - 1);
        acc_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            acc_data = rand_acc();
            tick();
            check("sim_credits", dut.credits_q, 1);
            check("sim_acc_ready", acc_ready, 1);
        end
        run_to_done(100, 100, 500);
        check("sim_outs", n_out, 30);

        // Zero-beat pass; cfg_start during DONE is ignored.
        start_pass(0, 3, 10, RELU_NONE);
        check("zero_done_early", done, 0);
        check("zero_busy", busy, 1);
        cfg_start = 1'b1; cfg_beats = BCW'(5);
        tick();
        cfg_start = 1'b0;
        check("zero_done", done, 1);
        check("zero_idle", busy, 0);
        tick();
        check("zero_done_pulse", done, 0);
        check("zero_start_ignored", busy, 0);
        check("zero_issues", n_issue, 0);

        // prm_we and cfg_start during RUN are ignored.
        start_pass(6, 3, 10, RELU_NONE);
        for (int c = 0; c < 4; c++) begin
            acc_valid = 1'b1; acc_data = rand_acc(); out_ready = 1'b1;
            prm_we = 1'b1; prm_addr = PAW'(c % 3); prm_wdata = '1;
            cfg_start = 1'b1; cfg_n = 5'd3; cfg_beats = BCW'(2);
            tick();
            check("ign_sc_n", sc_n, 10);
        end
        prm_we = 1'b0; cfg_start = 1'b0;
        run_to_done(100, 100, 200);
        check("ign_issues", n_issue, 6);
        check("ign_outs", n_out, 6);

        // Abort mid-pass, then a clean pass.
        start_pass(10, 3, 10, RELU_ON);
        acc_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            acc_data = rand_acc();
            tick();
        end
        acc_valid = 1'b0;
        check("abort_issued", n_issue, 3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_reset_outputs("abort");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_pass(4, 3, 10, RELU_NONE);
        run_to_done(100, 100, 200);
        check("abort_outs", n_out, 4);

        // Table-driven randomized passes over a random parameter table.
        for (int g = 0; g < 32; g++) write_prm(g, rand_mul());
        for (int v = 0; v < 5; v++) begin
            start_pass(vecs[v].beats, vecs[v].groups, vecs[v].n, vecs[v].relu);
            check("vec_sc_n", sc_n, vecs[v].n);
            check("vec_sc_relu", sc_relu, vecs[v].relu);
            run_to_done(vecs[v].vpct, vecs[v].rpct, 3000);
            check("vec_outs", n_out, vecs[v].exp_outs);
            check("vec_issues", n_issue, vecs[v].exp_outs);
        end
        check("final_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scale_sched.md
Name: scale_sched

Overview:
- Sequences the requantization (scale) datapath for one layer pass.
- Accepts accumulator beats from the ACC array and attaches per-channel-group scale multipliers from a local parameter table, plus the layer shift n and the relu mode.
- Issues each beat to the 4-cycle scale pipeline, which has no backpressure.
- Captures the returned 8-bit results in an output FIFO. A credit counter guarantees the pipeline can never overrun that FIFO.

Parameters:
- DN, 6, lanes per beat
- DW, 22, accumulator width per lane
- MULW, 9, scale multiplier width per lane
- OW, 8, output width per lane
- PAW, 5, parameter table address width (2^PAW channel groups)
- BCW, 16, beat counter width
- SCALE_LAT, 4, scale pipeline latency, m_valid1 to s_valid
- FDEPTH, 8, output FIFO depth (power of 2, >= SCALE_LAT)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_beats  in  BCW  total beats in the pass
- cfg_groups  in  PAW+1  channel groups per spatial position, 1..2^PAW
- cfg_n  in  5  shift amount for the layer
- cfg_relu  in  2  0x none, 10 relu, 11 leaky
- prm_we  in  1  parameter table write enable
- prm_addr  in  PAW  write address
- prm_wdata  in  DN*MULW  scale multipliers for one group
- acc_data  in  DN*DW  accumulator beat
- acc_valid  in  1  beat valid
- acc_ready  out  1  beat accepted when valid&&ready
- sc_data1  out  DN*DW  to scale m_data1
- sc_valid1  out  1  to scale m_valid1
- sc_data2  out  DN*MULW  to scale m_data2
- sc_n  out  5  to scale n
- sc_relu  out  2  to scale relu_en
- sc_sdata  in  DN*OW  from scale s_data
- sc_svalid  in  1  from scale s_valid
- out_data  out  DN*OW  result beat (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream pop
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky: sc_svalid arrived while FIFO full

Behaviour:
- Reset: state IDLE. All outputs 0, except sc_n and sc_relu, which also reset to 0. Credits = FDEPTH. FIFO empty. Parameter table contents undefined (not reset).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - prm_we writes the table.
  - On cfg_start: latch cfg_beats, cfg_groups, cfg_n and cfg_relu; clear the beat and group counters.
  - Go to RUN, or to DONE if cfg_beats==0.
  - prm_we outside IDLE is ignored.
- RUN issue rule:
  - acc_ready = (state==RUN) && (credits!=0), purely combinational from registers.
  - On handshake, in the same cycle: sc_valid1=1, sc_data1=acc_data, sc_data2=table[grp]. sc_data1, sc_data2 and sc_valid1 are combinational pass-through.
  - sc_n and sc_relu drive the latched layer values for the whole pass.
- Counters:
  - grp increments per issued beat and wraps from cfg_groups-1 to 0.
  - beat increments per issued beat. When the issue of beat cfg_beats-1 occurs, go to DRAIN.
- Credits:
  - Decrement on issue, increment on FIFO pop.
  - Simultaneous issue and pop leaves credits unchanged.
  - Credits never exceed FDEPTH.
- Return path: sc_svalid pushes sc_sdata into the FIFO unconditionally. If the FIFO is full, the data is dropped and err is set; err clears only on reset.
- FIFO:
  - First-word-fall-through; out_data is valid whenever out_valid=1.
  - Push and pop in the same cycle while full or empty are both legal.
  - Ordering is preserved.
- DRAIN: issue is blocked. Go to DONE when credits==FDEPTH, meaning the FIFO is empty and nothing is in flight.
- DONE: done=1 for one cycle, then go to IDLE. A cfg_start during DONE is ignored.
- Latency:
  - An accepted beat appears at the FIFO head SCALE_LAT+1 cycles after the handshake, if the FIFO was empty.
  - Sustained throughput is one beat per cycle while out_ready=1.
- Reset mid-pass: abort immediately. FIFO and counters clear, no done pulse; in-flight scale results returning after reset are the scale block's responsibility (it is reset too).

Decomposition:
- Shared package (acc_pkg):
  - relu mode constants RELU_NONE=2'b00, RELU_ON=2'b10, RELU_LEAKY=2'b11
  - SCALE_LAT
  - state enum type for scale_sched
- One sub-module: sync_fifo_fwft (parameters width and depth; ports push, pop, full, empty, count). It is instantiated once for the output FIFO.

Test Plan:
- Parameter mapping: write groups 0..2 with scale values 1, 2, 3 in every lane; start with beats=6, groups=3, n=10, relu=00, out_ready=1. Required: sc_data2 sequence is 1,2,3,1,2,3; six outputs appear; done pulses once after the last pop.
- Backpressure: out_ready=0 with acc_valid held at 1. Required: exactly 8 beats accepted, then acc_ready=0 with 8 entries in the FIFO and err=0. Releasing out_ready drains all entries in order.
- Simultaneous issue and pop at credits=1: credits stay 1 and acc_ready stays 1 continuously.
- cfg_beats=0: done asserts 2 cycles after cfg_start, with no sc_valid1.
- Ignored inputs: prm_we during RUN does not alter sc_data2 for the following beat; cfg_start during RUN does not change the latched n or the beat count.
- Abort: assert rst_n=0 after 3 of 10 beats. Required: all outputs return to 0 and credits=8; a new pass of 4 beats then completes normally with done.
